// File: rtl/seven_segment_reader.sv
// Snoops a multiplexed active-low seven-segment bus, debounces each digit dwell,
// decodes the segments back to hex nibbles and presents whole frames on valid/ready.
module seven_segment_reader #(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            seg_n,
  input  logic [DIGITS-1:0]     an_n,
  output logic [4*DIGITS-1:0]   value,
  output logic [DIGITS-1:0]     dp,
  output logic                  frame_err,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  overrun
);

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_HIT = CNT_W'(STABLE_CYCLES - 1);

  // Returns {invalid, nibble}; unknown patterns decode to nibble 0.
  function automatic logic [4:0] seg_decode(input logic [6:0] pat);
    logic [4:0] r;
    case (pat)
      7'h40: r = 5'h00;
      7'h79: r = 5'h01;
      7'h24: r = 5'h02;
      7'h30: r = 5'h03;
      7'h19: r = 5'h04;
      7'h12: r = 5'h05;
      7'h02: r = 5'h06;
      7'h78: r = 5'h07;
      7'h00: r = 5'h08;
      7'h10: r = 5'h09;
      7'h08: r = 5'h0A;
      7'h03: r = 5'h0B;
      7'h46: r = 5'h0C;
      7'h21: r = 5'h0D;
      7'h06: r = 5'h0E;
      7'h0E: r = 5'h0F;
      default: r = 5'h10;
    endcase
    return r;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == CNT_MAX) ? c : c + CNT_W'(1);
  endfunction

  logic [7:0]        seg_p0, seg_p1, seg_p2;
  logic [DIGITS-1:0] an_p0, an_p1, an_p2;
  logic [CNT_W-1:0]  cnt;

  logic [4*DIGITS-1:0] shadow;
  logic [DIGITS-1:0]   sdp, seen, serr;
  logic                done;

  logic [DIGITS-1:0] sel, capsel, seen_nxt, serr_nxt;
  logic              same, one_low, cap;
  logic [4:0]        dec;

  // Stage p0/p1: two-flop synchronizer (p1 = s); stage p2: one-cycle delay (p).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_p0 <= '1;
      seg_p1 <= '1;
      seg_p2 <= '1;
      an_p0  <= '1;
      an_p1  <= '1;
      an_p2  <= '1;
    end else begin
      seg_p0 <= seg_n;
      seg_p1 <= seg_p0;
      seg_p2 <= seg_p1;
      an_p0  <= an_n;
      an_p1  <= an_p0;
      an_p2  <= an_p1;
    end
  end

  always_comb begin
    sel      = ~an_p1;
    one_low  = $onehot(sel);
    same     = (seg_p1 == seg_p2) && (an_p1 == an_p2);
    cap      = same && one_low && (cnt == CNT_HIT);
    dec      = seg_decode(seg_p1[6:0]);
    capsel   = cap ? sel : '0;
    seen_nxt = (done ? '0 : seen) | capsel;
    serr_nxt = ((done ? '0 : serr) & ~capsel) | (dec[4] ? capsel : '0);
  end

  // Stability count: a dwell captures once, when the count reaches its last step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 cnt <= '0;
    else if (!same || !one_low) cnt <= '0;
    else                     cnt <= sat_inc(cnt);
  end

  // Capture into the shadow frame, then hand the frame to the output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow    <= '0;
      sdp       <= '0;
      seen      <= '0;
      serr      <= '0;
      done      <= 1'b0;
      value     <= '0;
      dp        <= '0;
      frame_err <= 1'b0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      for (int i = 0; i < DIGITS; i++) begin
        if (capsel[i]) begin
          shadow[4*i +: 4] <= dec[3:0];
          sdp[i]           <= ~seg_p1[7];
        end
      end
      seen <= seen_nxt;
      serr <= serr_nxt;
      done <= cap && (seen_nxt == '1);
      if (done) begin
        if (!out_valid || out_ready) begin
          value     <= shadow;
          dp        <= sdp;
          frame_err <= |serr;
          out_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seven_segment_reader.sv
// Randomized and directed bench for seven_segment_reader against a dwell-level reference model.
module tb_seven_segment_reader;
  localparam int DIGITS = 4;
  localparam int STABLE = 4;

  logic                clk = 1'b0;
  logic                rst;
  logic [7:0]          seg_n;
  logic [DIGITS-1:0]   an_n;
  logic [4*DIGITS-1:0] value;
  logic [DIGITS-1:0]   dp;
  logic                frame_err, out_valid, out_ready, overrun;

  seven_segment_reader #(.DIGITS(DIGITS), .STABLE_CYCLES(STABLE)) dut (
    .clk(clk), .rst(rst), .seg_n(seg_n), .an_n(an_n), .value(value), .dp(dp),
    .frame_err(frame_err), .out_valid(out_valid), .out_ready(out_ready), .overrun(overrun)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] PAT [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    int                edge_n;
    logic [DIGITS-1:0] an;
    logic [7:0]        seg;
  } cap_t;
  cap_t capq[$];

  logic                m_valid, m_err, m_ovr, m_done;
  logic [4*DIGITS-1:0] m_value, m_shadow;
  logic [DIGITS-1:0]   m_dp, m_sdp, m_seen, m_serr;

  int cyc      = 0;
  int rdy_mode = 1;
  int rdy_edge = -1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int decode_ref(input logic [6:0] pat);
    for (int i = 0; i < 16; i++) if (PAT[i] == pat) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_valid = 0; m_err = 0; m_ovr = 0; m_done = 0;
    m_value = '0; m_shadow = '0; m_dp = '0; m_sdp = '0; m_seen = '0; m_serr = '0;
    capq.delete();
  endtask

  // One clock edge of the reference: hand a completed frame over, then apply any
  // capture that the timing rules place on this edge.
  task automatic model_edge(input logic rdy);
    if (m_done) begin
      if (!m_valid || rdy) begin
        m_value = m_shadow; m_dp = m_sdp; m_err = |m_serr; m_valid = 1;
      end else begin
        m_ovr = 1;
      end
      m_seen = '0; m_serr = '0; m_done = 0;
    end else if (m_valid && rdy) begin
      m_valid = 0;
    end
    while (capq.size() > 0 && capq[0].edge_n == cyc) begin
      cap_t c;
      int   k, d;
      c = capq.pop_front();
      k = 0;
      for (int i = 0; i < DIGITS; i++) if (!c.an[i]) k = i;
      d = decode_ref(c.seg[6:0]);
      m_shadow[4*k +: 4] = (d < 0) ? 4'h0 : d[3:0];
      m_sdp[k]  = ~c.seg[7];
      m_serr[k] = (d < 0);
      m_seen[k] = 1'b1;
      if (m_seen == '1) m_done = 1;
    end
  endtask

  task automatic step(input logic [DIGITS-1:0] an, input logic [7:0] seg, input bit qual);
    cap_t c;
    @(negedge clk);
    check("out_valid", 32'(out_valid), 32'(m_valid));
    check("value", 32'(value), 32'(m_value));
    check("dp", 32'(dp), 32'(m_dp));
    check("frame_err", 32'(frame_err), 32'(m_err));
    check("overrun", 32'(overrun), 32'(m_ovr));
    an_n  = an;
    seg_n = seg;
    case (rdy_mode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'b1;
      2:       out_ready = 1'($urandom_range(0, 1));
      default: out_ready = (cyc + 1 == rdy_edge);
    endcase
    cyc++;
    if (qual) begin
      c.edge_n = cyc + STABLE + 2;
      c.an     = an;
      c.seg    = seg;
      capq.push_back(c);
    end
    model_edge(out_ready);
  endtask

  task automatic raw_dwell(input logic [DIGITS-1:0] an, input logic [7:0] seg, input int len);
    for (int i = 0; i < len; i++)
      step(an, seg, (i == 0) && (len >= STABLE + 1) && ($countones(~an) == 1));
  endtask

  task automatic dwell(input int dig, input logic [6:0] pat, input logic dpl, input int len);
    logic [DIGITS-1:0] a;
    a      = '1;
    a[dig] = 1'b0;
    raw_dwell(a, {~dpl, pat}, len);
  endtask

  task automatic blank(input int len);
    for (int i = 0; i < len; i++) step('1, 8'hFF, 1'b0);
  endtask

  task automatic frame4(input logic [6:0] p0, input logic [6:0] p1,
                        input logic [6:0] p2, input logic [6:0] p3);
    dwell(0, p0, 1'b0, 10); blank(2);
    dwell(1, p1, 1'b0, 10); blank(2);
    dwell(2, p2, 1'b0, 10); blank(2);
    dwell(3, p3, 1'b0, 10); blank(2);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_value", 32'(value), 32'd0);
    check("rst_dp", 32'(dp), 32'd0);
    check("rst_frame_err", 32'(frame_err), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    model_reset();
    an_n  = '1;
    seg_n = 8'hFF;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; an_n = '1; seg_n = 8'hFF; out_ready = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Idle display after reset: nothing is produced.
    blank(10);

    // Basic frame.
    rdy_mode = 1;
    frame4(7'h30, 7'h79, 7'h0E, 7'h40);
    blank(4);
    check("basic_value", 32'(value), 32'h0F13);
    check("basic_dp", 32'(dp), 32'd0);
    check("basic_err", 32'(frame_err), 32'd0);

    // Reset in the middle of a dwell clears the outputs at once.
    raw_dwell(4'b1110, 8'hF9, 3);
    do_reset();
    blank(3);

    // Glitch rejection: a 4-cycle dwell on digit 2 is ignored.
    dwell(0, 7'h40, 1'b0, 10); blank(2);
    dwell(1, 7'h79, 1'b0, 10); blank(2);
    dwell(2, 7'h24, 1'b0, 4);  blank(2);
    dwell(2, 7'h19, 1'b0, 10); blank(2);
    dwell(3, 7'h30, 1'b0, 10); blank(4);
    check("glitch_value", 32'(value), 32'h3410);

    // Undecodable pattern with the decimal point lit.
    dwell(0, 7'h24, 1'b0, 10); blank(2);
    dwell(1, 7'h7F, 1'b1, 10); blank(2);
    dwell(2, 7'h30, 1'b0, 10); blank(2);
    dwell(3, 7'h19, 1'b0, 10); blank(4);
    check("inval_value", 32'(value), 32'h4302);
    check("inval_dp", 32'(dp), 32'b0010);
    check("inval_err", 32'(frame_err), 32'd1);

    // Acceptance on the very edge the next frame completes.
    rdy_mode = 0;
    frame4(7'h40, 7'h40, 7'h40, 7'h79);
    rdy_mode = 3;
    dwell(0, 7'h0E, 1'b0, 10); blank(2);
    dwell(1, 7'h46, 1'b0, 10); blank(2);
    dwell(2, 7'h21, 1'b0, 10); blank(2);
    rdy_edge = cyc + 1 + STABLE + 3;
    dwell(3, 7'h08, 1'b0, 10); blank(4);
    check("simul_valid", 32'(out_valid), 32'd1);
    check("simul_value", 32'(value), 32'hADCF);
    check("simul_overrun", 32'(overrun), 32'd0);

    // Backpressure: second frame is dropped and overrun sticks.
    rdy_mode = 1;
    blank(3);
    rdy_mode = 0;
    frame4(7'h19, 7'h30, 7'h24, 7'h79);
    frame4(7'h00, 7'h78, 7'h02, 7'h12);
    check("bp_value", 32'(value), 32'h1234);
    check("bp_overrun", 32'(overrun), 32'd1);
    check("bp_valid", 32'(out_valid), 32'd1);
    rdy_mode = 1;
    blank(1);
    rdy_mode = 0;
    blank(3);
    check("bp_drained", 32'(out_valid), 32'd0);
    check("bp_overrun_sticky", 32'(overrun), 32'd1);

    // Randomized traffic with random backpressure.
    do_reset();
    rdy_mode = 2;
    for (int n = 0; n < 150; n++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r < 8) begin
        logic [6:0] pat;
        pat = (r < 7) ? PAT[$urandom_range(0, 15)] : 7'($urandom);
        dwell($urandom_range(0, DIGITS - 1), pat, 1'($urandom_range(0, 1)), $urandom_range(1, 12));
      end else if (r == 8) begin
        logic [DIGITS-1:0] a;
        int i, j;
        a = '1;
        i = $urandom_range(0, DIGITS - 1);
        j = (i + 1 + $urandom_range(0, DIGITS - 2)) % DIGITS;
        a[i] = 1'b0;
        a[j] = 1'b0;
        raw_dwell(a, {1'b1, PAT[$urandom_range(0, 15)]}, $urandom_range(5, 12));
      end else begin
        blank($urandom_range(3, 8));
      end
      blank($urandom_range(1, 3));
    end
    blank(12);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
